// File: rtl/cavlc_bitstream_shifter.sv
// ---------------------------------------------------------------------------
// cavlc_bitstream_shifter
//
// Bitstream alignment stage that sits in front of the coeff_token LUT bank.
// Raw slice data comes in as 32-bit words (MSB first). The words are packed
// into a 64-bit left-justified window, and the next 16 unconsumed bits are
// presented MSB-aligned. Each cycle the LUT bank can hand back the length of
// the codeword it decoded, which lets one codeword retire per cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   in_data     next bitstream word; in_data[31] is earliest in the stream
//   in_valid    in_data is valid
//   in_ready    the block accepts in_data this cycle
//   flush       one-cycle pulse; discards all buffered bits (slice restart)
//   bits        next 16 unconsumed bits; bits[15] is the next bit in stream
//   bits_valid  at least 16 valid bits are buffered
//   shift       number of bits to consume, legal range 0..16
//   shift_en    apply shift this cycle
//   bit_count   number of valid bits in the window, 0..64
//   err         sticky illegal-shift flag, cleared by reset or flush
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready comes only from the registered bit count (plus
// rst_n and flush). It never depends on in_valid or shift_en, so there is
// no combinational loop with the upstream FIFO. Once in_valid is raised,
// the FIFO holds in_data stable until the transfer happens.
// ---------------------------------------------------------------------------
module cavlc_bitstream_shifter #(
    parameter int IN_W   = 32,
    parameter int PEEK_W = 16,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [PEEK_W-1:0] bits,
    output logic              bits_valid,
    input  logic [4:0]        shift,
    input  logic              shift_en,
    output logic [6:0]        bit_count,
    output logic              err
);

    // Window state: valid bits occupy window_q[63 -: count_q].
    // Everything below the valid region is held at zero.
    logic [BUF_W-1:0] window_q;
    logic [6:0]       count_q;
    logic             err_q;

    logic             shift_legal;
    logic             accept;
    logic [6:0]       shift_amt;
    logic [6:0]       base;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] incoming;
    logic [BUF_W-1:0] window_d;
    logic [6:0]       count_d;

    assign bits_valid  = (count_q >= 7'd16);
    assign in_ready    = rst_n & ~flush & (count_q <= 7'd32);
    assign shift_legal = shift_en & bits_valid & (shift <= 5'd16);
    assign accept      = in_valid & in_ready;

    always_comb begin
        shift_amt = 7'd0;
        if (shift_legal) begin
            shift_amt = {2'b00, shift};
        end
        // Valid bits that remain after the shift. Because a shift is only
        // legal with at least 16 bits buffered, and at most 16 are removed,
        // this never goes below zero.
        base    = count_q - shift_amt;
        shifted = window_q << shift_amt;
        // The new word goes in directly behind the post-shift valid region.
        // An accept requires count_q <= 32, so base <= 32 and the whole word
        // fits inside the window.
        incoming = '0;
        if (accept) begin
            incoming = {in_data, {IN_W{1'b0}}} >> base;
        end
        window_d = shifted | incoming;
        count_d  = base + (accept ? 7'd32 : 7'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_q <= '0;
            count_q  <= 7'd0;
            err_q    <= 1'b0;
        end else if (flush) begin
            window_q <= '0;
            count_q  <= 7'd0;
            err_q    <= 1'b0;
        end else begin
            window_q <= window_d;
            count_q  <= count_d;
            // An illegal request consumes nothing (shift_amt stays 0).
            // It only raises the flag.
            if (shift_en && !shift_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bits      = window_q[BUF_W-1 -: PEEK_W];
    assign bit_count = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
module tb_cavlc_bitstream_shifter;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] bits;
  logic        bits_valid;
  logic [4:0]  shift;
  logic        shift_en;
  logic [6:0]  bit_count;
  logic        err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cavlc_bitstream_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .bits       (bits),
    .bits_valid (bits_valid),
    .shift      (shift),
    .shift_en   (shift_en),
    .bit_count  (bit_count),
    .err        (err)
  );

  // ---------------- scoreboard / reference model ----------------
  // The model is the unconsumed bitstream itself, one entry per bit, with
  // the earliest bit at the front. It is kept together with a sticky error flag.
  logic [0:0] exp_q[$];
  logic       exp_err;
  int         checks;
  int         errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bits();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < exp_q.size()) r[15-i] = exp_q[i];
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_bits"},       {48'd0, bits},           {48'd0, model_bits()});
    check({tag, "_bits_valid"}, {63'd0, bits_valid},     {63'd0, (exp_q.size() >= 16)});
    check({tag, "_bit_count"},  {57'd0, bit_count},      64'(exp_q.size()));
    check({tag, "_err"},        {63'd0, err},            {63'd0, exp_err});
  endtask

  // ---------------- driver tasks ----------------
  // Call at posedge+1. The task drives one cycle, checks in_ready before the
  // edge, advances the model across the edge, and then checks the registered outputs.
  task automatic cycle(input string tag, input logic vld, input logic [31:0] data,
                       input logic sen, input logic [4:0] sh, input logic fl);
    logic exp_ready;
    logic legal;
    in_valid = vld;
    in_data  = data;
    shift_en = sen;
    shift    = sh;
    flush    = fl;
    #1;
    exp_ready = rst_n && !fl && (exp_q.size() <= 32);
    check({tag, "_in_ready"}, {63'd0, in_ready}, {63'd0, exp_ready});
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      legal = sen && (exp_q.size() >= 16) && (sh <= 16);
      if (sen && !legal) exp_err = 1'b1;
      if (legal) begin
        for (int i = 0; i < int'(sh); i++) void'(exp_q.pop_front());
      end
      if (vld && exp_ready) begin
        for (int i = 31; i >= 0; i--) exp_q.push_back(data[i]);
      end
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    shift_en = 1'b0;
    shift    = 5'd0;
    flush    = 1'b0;
    #1;
    check({tag, "_in_ready_in_reset"}, {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_in_ready_in_reset2"}, {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    exp_err = 1'b0;
    check_outputs(tag);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    exp_err  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    shift_en = 1'b0;
    shift    = '0;
    flush    = 1'b0;

    do_reset("rst");
    check("rst_bits_zero", {48'd0, bits}, 64'd0);

    // Load two words
    cycle("t1a", 1'b1, 32'h12345678, 1'b0, 5'd0, 1'b0);
    check("t1a_bits_c",  {48'd0, bits},      64'h1234);
    check("t1a_count_c", {57'd0, bit_count}, 64'd32);
    check("t1a_ready_c", {63'd0, in_ready},  64'd1);
    cycle("t1b", 1'b1, 32'h9ABCDEF0, 1'b0, 5'd0, 1'b0);
    check("t1b_count_c", {57'd0, bit_count}, 64'd64);
    check("t1b_ready_c", {63'd0, in_ready},  64'd0);

    // Shift sequence
    cycle("t2a", 1'b0, 32'h0, 1'b1, 5'd4, 1'b0);
    check("t2a_bits_c",  {48'd0, bits},      64'h2345);
    check("t2a_count_c", {57'd0, bit_count}, 64'd60);
    cycle("t2b", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
    check("t2b_bits_c",  {48'd0, bits},      64'h6789);
    check("t2b_count_c", {57'd0, bit_count}, 64'd44);
    cycle("t2c", 1'b0, 32'h0, 1'b1, 5'd12, 1'b0);
    check("t2c_bits_c",  {48'd0, bits},      64'h9ABC);
    check("t2c_count_c", {57'd0, bit_count}, 64'd32);

    // Shift and accept on the same edge
    cycle("t3a", 1'b1, 32'h0F0F0F0F, 1'b1, 5'd8, 1'b0);
    check("t3a_bits_c",  {48'd0, bits},      64'hBCDE);
    check("t3a_count_c", {57'd0, bit_count}, 64'd56);
    cycle("t3b", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
    check("t3b_bits_c",  {48'd0, bits},      64'hF00F);

    // Underflow and over-range shifts
    cycle("t4a", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
    cycle("t4b", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
    check("t4b_count_c", {57'd0, bit_count}, 64'd8);
    cycle("t4c", 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
    check("t4c_err_c",   {63'd0, err},       64'd1);
    check("t4c_count_c", {57'd0, bit_count}, 64'd8);
    check("t4c_bits_c",  {48'd0, bits},      64'h0F00);
    cycle("t4d", 1'b1, 32'h13579BDF, 1'b0, 5'd0, 1'b0);
    cycle("t4e", 1'b0, 32'h0, 1'b1, 5'd17, 1'b0);
    check("t4e_count_c", {57'd0, bit_count}, 64'd40);
    check("t4e_bits_c",  {48'd0, bits},      64'h0F13);

    // Flush while a word is pending
    cycle("t5a", 1'b1, 32'hCAFEF00D, 1'b1, 5'd4, 1'b1);
    check("t5a_count_c", {57'd0, bit_count}, 64'd0);
    check("t5a_err_c",   {63'd0, err},       64'd0);
    cycle("t5b", 1'b1, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    check("t5b_count_c", {57'd0, bit_count}, 64'd32);
    check("t5b_bits_c",  {48'd0, bits},      64'hCAFE);

    // Random stream of legal shifts
    for (int n = 0; n < 10000; n++) begin
      logic        vld;
      logic        sen;
      logic [4:0]  sh;
      logic        fl;
      vld = ($urandom_range(0, 3) != 0);
      sen = (exp_q.size() >= 16) && ($urandom_range(0, 4) != 0);
      sh  = 5'($urandom_range(0, 16));
      fl  = ($urandom_range(0, 299) == 0);
      cycle("rnd", vld, $urandom, sen, sh, fl);
      if (bit_count > 7'd64) check("rnd_count_range", {57'd0, bit_count}, 64'd64);
    end

    // Reset in the middle of a stream
    cycle("pre_rst", 1'b1, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
    do_reset("mid_rst");
    cycle("post_rst", 1'b1, 32'h0BADF00D, 1'b0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
